// File: rtl/rs_encoder_line_demux_in_ctrl.sv
// rs_encoder_line_demux_in_ctrl
//   Input side of the RS encoder line mux. Takes DATA_W-bit lines from the
//   source, serializes each line MSB-byte first, and feeds RS_K bytes to one
//   RS unit before handing off to the output controller and moving on to the
//   next unit (round-robin).
// Ports
//   clk, rst_n                 clock, async active-low reset
//   src_encoder_line_val/data  source line stream (byte 0 = top byte)
//   encoder_src_line_rdy       line accepted when val & rdy
//   in_ctrl_unit_sel           one-hot unit currently being fed
//   in_ctrl_encoder_byte_val   byte valid towards the selected unit
//   in_ctrl_encoder_byte       byte towards the selected unit
//   encoder_in_ctrl_byte_rdy   selected unit ready (muxed outside)
//   in_ctrl_out_ctrl_done      this side finished feeding the current unit
//   out_ctrl_in_ctrl_done      output side finished draining the current unit
module rs_encoder_line_demux_in_ctrl #(
    parameter int NUM_RS_UNITS   = 4,
    parameter int NUM_RS_UNITS_W = $clog2(NUM_RS_UNITS),
    parameter int DATA_W         = 256,
    parameter int RS_K           = 224
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    src_encoder_line_val,
    input  logic [DATA_W-1:0]       src_encoder_line_data,
    output logic                    encoder_src_line_rdy,
    output logic [NUM_RS_UNITS-1:0] in_ctrl_unit_sel,
    output logic                    in_ctrl_encoder_byte_val,
    output logic [7:0]              in_ctrl_encoder_byte,
    input  logic                    encoder_in_ctrl_byte_rdy,
    output logic                    in_ctrl_out_ctrl_done,
    input  logic                    out_ctrl_in_ctrl_done
);

    localparam int LINE_BYTES    = DATA_W / 8;
    localparam int LINES_PER_BLK = RS_K / LINE_BYTES;
    // Counters keep at least one bit so degenerate sizes (1 byte/line,
    // 1 line/block, 1 unit) still elaborate; the counter then stays at 0.
    localparam int BC_W = (LINE_BYTES > 1)    ? $clog2(LINE_BYTES)    : 1;
    localparam int LC_W = (LINES_PER_BLK > 1) ? $clog2(LINES_PER_BLK) : 1;
    localparam int UI_W = (NUM_RS_UNITS_W > 0) ? NUM_RS_UNITS_W : 1;

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(LINE_BYTES - 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LINES_PER_BLK - 1);
    localparam logic [UI_W-1:0] UI_LAST = UI_W'(NUM_RS_UNITS - 1);

    typedef enum logic [1:0] {
        READY      = 2'd0,
        SEND_BYTES = 2'd1,
        LINE_WAIT  = 2'd2,
        DONE_WAIT  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] line_reg, line_reg_n;
    logic [BC_W-1:0]   byte_cnt, byte_cnt_n;
    logic [LC_W-1:0]   line_cnt, line_cnt_n;
    logic [UI_W-1:0]   unit_idx, unit_idx_n;
    logic [DATA_W-1:0] line_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= READY;
            line_reg <= '0;
            byte_cnt <= '0;
            line_cnt <= '0;
            unit_idx <= '0;
        end else begin
            state    <= state_n;
            line_reg <= line_reg_n;
            byte_cnt <= byte_cnt_n;
            line_cnt <= line_cnt_n;
            unit_idx <= unit_idx_n;
        end
    end

    always_comb begin
        state_n                  = state;
        line_reg_n               = line_reg;
        byte_cnt_n               = byte_cnt;
        line_cnt_n               = line_cnt;
        unit_idx_n               = unit_idx;
        encoder_src_line_rdy     = 1'b0;
        in_ctrl_encoder_byte_val = 1'b0;
        in_ctrl_out_ctrl_done    = 1'b0;
        case (state)
            READY: begin
                encoder_src_line_rdy = 1'b1;
                if (src_encoder_line_val) begin
                    line_reg_n = src_encoder_line_data;
                    byte_cnt_n = '0;
                    line_cnt_n = '0;
                    state_n    = SEND_BYTES;
                end
            end
            SEND_BYTES: begin
                in_ctrl_encoder_byte_val = 1'b1;
                if (encoder_in_ctrl_byte_rdy) begin
                    if (byte_cnt != BC_LAST) begin
                        byte_cnt_n = byte_cnt + BC_W'(1);
                    end else begin
                        byte_cnt_n = '0;
                        if (line_cnt != LC_LAST) begin
                            line_cnt_n = line_cnt + LC_W'(1);
                            state_n    = LINE_WAIT;
                        end else begin
                            line_cnt_n = '0;
                            state_n    = DONE_WAIT;
                        end
                    end
                end
            end
            LINE_WAIT: begin
                encoder_src_line_rdy = 1'b1;
                if (src_encoder_line_val) begin
                    line_reg_n = src_encoder_line_data;
                    state_n    = SEND_BYTES;
                end
            end
            DONE_WAIT: begin
                // Unit index only moves here, so unit_sel is stable for the
                // whole time bytes are being offered.
                in_ctrl_out_ctrl_done = 1'b1;
                if (out_ctrl_in_ctrl_done) begin
                    if (unit_idx == UI_LAST) begin
                        unit_idx_n = '0;
                        state_n    = READY;
                    end else begin
                        unit_idx_n = unit_idx + UI_W'(1);
                        state_n    = LINE_WAIT;
                    end
                end
            end
            default: state_n = state_t'('x);
        endcase
    end

    // Current byte is the top byte of the line shifted left by byte_cnt bytes.
    assign line_shift           = line_reg << {byte_cnt, 3'b000};
    assign in_ctrl_encoder_byte = line_shift[DATA_W-1 -: 8];
    assign in_ctrl_unit_sel     = NUM_RS_UNITS'(1) << unit_idx;

endmodule

// File: tb/tb_rs_encoder_line_demux_in_ctrl.sv
// Directed bench for rs_encoder_line_demux_in_ctrl (2 units, 64-bit lines,
// 16-byte blocks). Inputs change and outputs are checked on the falling edge;
// handshakes are observed on the rising edge.
module tb_rs_encoder_line_demux_in_ctrl;

    localparam int N  = 2;
    localparam int DW = 64;
    localparam int K  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          val = 1'b0;
    logic [DW-1:0] data = '0;
    logic          line_rdy;
    logic [N-1:0]  sel;
    logic          byte_val;
    logic [7:0]    byte_o;
    logic          byte_rdy = 1'b1;
    logic          done;
    logic          od = 1'b0;

    always #5 clk = ~clk;

    rs_encoder_line_demux_in_ctrl #(
        .NUM_RS_UNITS(N), .DATA_W(DW), .RS_K(K)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .src_encoder_line_val     (val),
        .src_encoder_line_data    (data),
        .encoder_src_line_rdy     (line_rdy),
        .in_ctrl_unit_sel         (sel),
        .in_ctrl_encoder_byte_val (byte_val),
        .in_ctrl_encoder_byte     (byte_o),
        .encoder_in_ctrl_byte_rdy (byte_rdy),
        .in_ctrl_out_ctrl_done    (done),
        .out_ctrl_in_ctrl_done    (od)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] src_q[$];
    logic [7:0]  got_q[$];
    bit          rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit          use_pat = 0;
    bit          od_v = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          stab_viol = 0;
    int          sel_viol = 0;
    int          hold_cnt = 0;
    logic [1:0]  exp_sel = 2'b01;
    bit          prev_hold = 0;
    logic [7:0]  prev_byte = '0;

    function automatic logic [63:0] mk(input logic [7:0] b);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[63-8*i -: 8] = b + 8'(i);
        return r;
    endfunction

    task automatic drive();
        val      = (src_q.size() > 0);
        data     = (src_q.size() > 0) ? src_q[0] : '0;
        byte_rdy = use_pat ? rdy_pat[cyc % 4] : 1'b1;
        od       = od_v;
    endtask

    task automatic step();
        @(posedge clk);
        if (prev_hold && (!byte_val || byte_o !== prev_byte)) stab_viol++;
        prev_hold = byte_val && !byte_rdy;
        prev_byte = byte_o;
        if (prev_hold) hold_cnt++;
        if (byte_val && sel !== exp_sel) sel_viol++;
        if (byte_val && byte_rdy) got_q.push_back(byte_o);
        if (val && line_rdy) void'(src_q.pop_front());
        if (done && od) hs_cnt++;
        cyc++;
        @(negedge clk);
        drive();
    endtask

    task automatic wait_bytes(input int n, input int bound);
        for (int i = 0; i < bound && got_q.size() < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive();
        step(); step();
        checks++; if (byte_val !== 1'b0) begin errors++; $display("FAIL reset_byte_val: got %b want 0", byte_val); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sel !== 2'b01) begin errors++; $display("FAIL reset_sel: got %b want 01", sel); end
        checks++; if (line_rdy !== 1'b1) begin errors++; $display("FAIL reset_line_rdy: got %b want 1", line_rdy); end
        checks++; if (byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", byte_o); end
        rst_n = 1'b1;
        src_q.push_back(mk(8'hA0));
        drive();
        step(); step();
        checks++; if (byte_val !== 1'b1) begin errors++; $display("FAIL pre_reset_sending: got %b want 1", byte_val); end
        rst_n = 1'b0;
        src_q.delete();
        drive();
        step();
        checks++; if (byte_val !== 1'b0 || done !== 1'b0 || sel !== 2'b01 || line_rdy !== 1'b1)
            begin errors++; $display("FAIL midblock_reset: got val=%b done=%b sel=%b rdy=%b want 0 0 01 1", byte_val, done, sel, line_rdy); end
        rst_n = 1'b1;
        got_q.delete();
        prev_hold = 0;
        step();
    endtask

    task automatic test_full_block();
        exp_sel = 2'b01; od_v = 0; use_pat = 0;
        src_q.push_back(64'h0001020304050607);
        src_q.push_back(64'h08090A0B0C0D0E0F);
        drive();
        step();
        checks++; if (byte_val !== 1'b1 || byte_o !== 8'h00)
            begin errors++; $display("FAIL first_byte_latency: got val=%b byte=%h want 1 00", byte_val, byte_o); end
        wait_bytes(16, 40);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL full_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_q[i] !== 8'(i)) begin errors++; $display("FAIL full_byte%0d: got %h want %h", i, got_q[i], 8'(i)); end
        end
        checks++; if (sel_viol != 0) begin errors++; $display("FAIL full_sel: got %0d bad cycles want 0", sel_viol); end
        checks++; if (done !== 1'b1 || line_rdy !== 1'b0 || byte_val !== 1'b0)
            begin errors++; $display("FAIL done_wait_outs: got done=%b rdy=%b val=%b want 1 0 0", done, line_rdy, byte_val); end
    endtask

    task automatic test_done_handshake();
        for (int i = 0; i < 5; i++) begin
            checks++; if (done !== 1'b1 || sel !== 2'b01)
                begin errors++; $display("FAIL hs_hold%0d: got done=%b sel=%b want 1 01", i, done, sel); end
            step();
        end
        od_v = 1; drive();
        step();
        checks++; if (sel !== 2'b10 || line_rdy !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL hs_advance: got sel=%b rdy=%b done=%b want 10 1 0", sel, line_rdy, done); end
        od_v = 0; drive();
    endtask

    task automatic test_wrap();
        int h0;
        exp_sel = 2'b10; got_q.delete(); od_v = 1;
        h0 = hs_cnt;
        src_q.push_back(mk(8'h10));
        src_q.push_back(mk(8'h18));
        drive();
        for (int i = 0; i < 60 && hs_cnt == h0; i++) step();
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL wrap_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_q[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, got_q[i], 8'(8'h10 + i)); end
        end
        checks++; if (sel_viol != 0) begin errors++; $display("FAIL wrap_sel_during: got %0d bad cycles want 0", sel_viol); end
        checks++; if (hs_cnt != h0 + 1 || sel !== 2'b01 || line_rdy !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL wrap_ready: got hs=%0d sel=%b rdy=%b done=%b want %0d 01 1 0", hs_cnt, sel, line_rdy, done, h0 + 1); end
        od_v = 0; drive();
    endtask

    task automatic test_backpressure();
        exp_sel = 2'b01; got_q.delete(); use_pat = 1;
        src_q.push_back(mk(8'h20));
        src_q.push_back(mk(8'h28));
        drive();
        wait_bytes(16, 200);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL bp_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_q[i] !== 8'(8'h20 + i)) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], 8'(8'h20 + i)); end
        end
        checks++; if (hold_cnt == 0 || stab_viol != 0)
            begin errors++; $display("FAIL bp_stable: got holds=%0d unstable=%0d want >0 0", hold_cnt, stab_viol); end
        checks++; if (sel_viol != 0) begin errors++; $display("FAIL bp_sel: got %0d bad cycles want 0", sel_viol); end
        use_pat = 0; od_v = 1; drive();
        step();
        checks++; if (sel !== 2'b10) begin errors++; $display("FAIL bp_next_unit: got %b want 10", sel); end
        od_v = 0; drive();
    endtask

    task automatic test_source_stall();
        exp_sel = 2'b10; got_q.delete();
        src_q.push_back(mk(8'h30));
        drive();
        wait_bytes(8, 40);
        for (int i = 0; i < 3; i++) begin
            checks++; if (byte_val !== 1'b0 || line_rdy !== 1'b1 || byte_o !== 8'h30)
                begin errors++; $display("FAIL stall%0d: got val=%b rdy=%b byte=%h want 0 1 30", i, byte_val, line_rdy, byte_o); end
            step();
        end
        src_q.push_back(mk(8'h38));
        drive();
        wait_bytes(16, 40);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL stall_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_q[i] !== 8'(8'h30 + i)) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, got_q[i], 8'(8'h30 + i)); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
        od_v = 1; drive();
        step();
        checks++; if (sel !== 2'b01 || line_rdy !== 1'b1)
            begin errors++; $display("FAIL stall_wrap: got sel=%b rdy=%b want 01 1", sel, line_rdy); end
        od_v = 0; drive();
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_done_handshake();
        test_wrap();
        test_backpressure();
        test_source_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
